// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and sizes for the pipeline hazard controller.
package pipe_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {RUN, HAZARD, FENCE} state_e;
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: one pending bit per register for loads in flight; set beats clear, x0 never pending.
module load_scoreboard
  import pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_i,
  input  logic [REG_IDX_W-1:0] set_idx_i,
  input  logic                 clr_i,
  input  logic [REG_IDX_W-1:0] clr_idx_i,
  output logic [NUM_REGS-1:0]  pending_o
);
  logic [NUM_REGS-1:0] pending_q, pending_d;
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_idx_i] = 1'b0;
    if (set_i) pending_d[set_idx_i] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else pending_q <= pending_d;
  end
  assign pending_o = pending_q;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: load-use / busy-EX / fence stall control with branch flush and a saturating stall counter.
module pipeline_controller
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  input  logic                 id_is_load,
  input  logic                 id_is_fence,
  input  logic                 ex_busy,
  input  logic                 ex_branch_taken,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic                 flush_id,
  output logic [NUM_REGS-1:0]  pending,
  output logic [CNT_W-1:0]     stall_cnt
);
  state_e state_q, state_d;
  logic raw_hit, hazard, fence_wait, cond, issue;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  assign issue = id_valid & ~stall_id & ~ex_branch_taken;
  load_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_i     (issue & id_is_load & (|id_rd)),
    .set_idx_i (id_rd),
    .clr_i     (wb_valid),
    .clr_idx_i (wb_rd),
    .pending_o (pending)
  );
  assign raw_hit = (id_use_rs1 & pending[id_rs1] & (|id_rs1)) | (id_use_rs2 & pending[id_rs2] & (|id_rs2));
  assign hazard = raw_hit | ex_busy;
  assign fence_wait = (|pending) | ex_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     state_d = !id_valid ? RUN : (id_is_fence && fence_wait) ? FENCE : hazard ? HAZARD : RUN;
      HAZARD:  state_d = hazard ? HAZARD : RUN;
      FENCE:   state_d = fence_wait ? FENCE : RUN;
      default: state_d = RUN;
    endcase
    if (ex_branch_taken) state_d = RUN;
  end
  // While in FENCE the wait depends only on the scoreboard and EX, not on the decoded fence bit.
  always_comb begin
    cond = (state_q == FENCE) ? fence_wait : (state_q == HAZARD) ? hazard : (id_is_fence & fence_wait) | hazard;
    stall_id = rst_n & id_valid & ~ex_branch_taken & cond;
    stall_if = stall_id;
    bubble_ex = ex_branch_taken | stall_id;
    flush_id = ex_branch_taken;
  end
  assign stall_cnt_d = (stall_id && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vector table plus saturation and reset sequences.
module tb_pipeline_controller;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, id_is_load, id_is_fence, ex_busy, ex_branch_taken, wb_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic stall_if, stall_id, bubble_ex, flush_id;
  logic [31:0] pending;
  logic [7:0] stall_cnt;
  int errors = 0, checks = 0;

  typedef struct {
    logic v; logic [4:0] rs1, rs2; logic u1, u2; logic [4:0] rd; logic ld, fe, busy, br, wb; logic [4:0] wbrd;
    logic stall, bub, flush; logic [31:0] pend; logic [7:0] cnt;
  } vec_t;
  vec_t tbl[36];

  pipeline_controller #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_is_fence(id_is_fence), .ex_busy(ex_busy), .ex_branch_taken(ex_branch_taken),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .pending(pending), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t t);
    id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2; id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_rd = t.rd; id_is_load = t.ld; id_is_fence = t.fe; ex_busy = t.busy;
    ex_branch_taken = t.br; wb_valid = t.wb; wb_rd = t.wbrd;
  endtask

  task automatic check_vec(input string tag, input vec_t t);
    chk({tag, " stall_id"}, 32'(stall_id), 32'(t.stall));
    chk({tag, " stall_if"}, 32'(stall_if), 32'(t.stall));
    chk({tag, " bubble_ex"}, 32'(bubble_ex), 32'(t.bub));
    chk({tag, " flush_id"}, 32'(flush_id), 32'(t.flush));
    chk({tag, " pending"}, pending, t.pend);
    chk({tag, " stall_cnt"}, 32'(stall_cnt), 32'(t.cnt));
  endtask

  initial begin
    vec_t idle, t;
    //                v rs1 rs2 u1 u2 rd ld fe busy br wb wbrd  stall bub flush pend cnt
    idle = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    tbl[1]  = '{1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   0};
    tbl[2]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20,  0};
    tbl[3]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h20,  1};
    tbl[4]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 1, 0, 32'h20,  2};
    tbl[5]  = '{1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   3};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   3};
    tbl[7]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   3};
    tbl[8]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   3};
    tbl[9]  = '{1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 1, 9, 0, 0, 0, 32'h200, 3};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 3};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 32'h200, 3};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0, 32'h0,  3};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   3};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0,   3};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 32'h0,   4};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4};
    tbl[17] = '{1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   4};
    tbl[18] = '{1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8,   4};
    tbl[19] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h88,  4};
    tbl[20] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 1, 1, 0, 32'h88,  5};
    tbl[21] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 7, 1, 1, 0, 32'h80,  6};
    tbl[22] = '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 32'h0,   7};
    tbl[23] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0,   8};
    tbl[24] = '{1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   8};
    tbl[25] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 32'h10,  8};
    tbl[26] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h10,  9};
    tbl[27] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10,  9};
    tbl[28] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 32'h10,  9};
    tbl[29] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   9};
    tbl[30] = '{1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,   9};
    tbl[31] = '{1, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h40,  9};
    tbl[32] = '{1, 0, 6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'h40, 10};
    tbl[33] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 10};
    tbl[34] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 32'h40, 10};
    tbl[35] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,  10};

    // In reset with a would-be busy stall: outputs must stay quiet
    rst_n = 1'b0;
    t = idle; t.v = 1; t.busy = 1;
    apply(t);
    #2;
    check_vec("reset", idle);
    apply(idle);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Saturation: load x2, then hold a use of x2 for 300 stall cycles
    @(negedge clk);
    t = idle; t.v = 1; t.rd = 2; t.ld = 1;
    apply(t);
    @(negedge clk);
    t = idle; t.v = 1; t.rs1 = 2; t.u1 = 1;
    apply(t);
    #1;
    chk("sat first stall", 32'(stall_id), 1);
    chk("sat pending", pending, 32'h4);
    repeat (299) @(negedge clk);
    #1;
    chk("sat stall held", 32'(stall_id), 1);
    chk("sat stall_cnt", 32'(stall_cnt), 255);

    // Asynchronous reset mid-stall
    rst_n = 1'b0;
    #1;
    chk("rst stall_id", 32'(stall_id), 0);
    chk("rst stall_if", 32'(stall_if), 0);
    chk("rst bubble_ex", 32'(bubble_ex), 0);
    chk("rst flush_id", 32'(flush_id), 0);
    chk("rst pending", pending, 0);
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    ex_branch_taken = 1'b1;
    #1;
    chk("rst br flush_id", 32'(flush_id), 1);
    chk("rst br bubble_ex", 32'(bubble_ex), 1);
    chk("rst br stall_id", 32'(stall_id), 0);
    ex_branch_taken = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post rst stall_id", 32'(stall_id), 0);
    @(negedge clk);
    #1;
    chk("post rst stall again", 32'(stall_id), 0);
    chk("post rst stall_cnt", 32'(stall_cnt), 0);

    // Reset during FENCE wait
    @(negedge clk);
    t = idle; t.v = 1; t.rd = 3; t.ld = 1;
    apply(t);
    @(negedge clk);
    t = idle; t.v = 1; t.fe = 1;
    apply(t);
    #1;
    chk("fence pre-rst stall", 32'(stall_id), 1);
    rst_n = 1'b0;
    #1;
    chk("fence rst stall", 32'(stall_id), 0);
    chk("fence rst pending", pending, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("fence post rst stall", 32'(stall_id), 0);
    @(negedge clk);
    #1;
    chk("fence post rst cnt", 32'(stall_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
